// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry, line/beat sizing, bridge states.
// Used by the cache controller and the memory bridge.
package cache_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int LINE_BYTES     = 64;
  localparam int LINE_SIZE_BITS = LINE_BYTES * 8;
  localparam int OFFSET_W       = $clog2(LINE_BYTES);
  localparam int NUM_WAYS       = 4;
  localparam int NUM_SETS       = 64;
  localparam int INDEX_W        = $clog2(NUM_SETS);
  localparam int TAG_W          = ADDR_BITS - INDEX_W - OFFSET_W;
  localparam int MEM_BEAT_BITS  = 32;
  localparam int BEATS          = LINE_SIZE_BITS / MEM_BEAT_BITS;
  localparam int BEAT_BYTES     = MEM_BEAT_BITS / 8;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_WB,
    BR_RD,
    BR_RESP
  } bridge_state_t;

endpackage

// File: rtl/beat_counter.sv
// Beat index within a line burst.
// Advances on ack, wraps after the last beat.
module beat_counter #(
  parameter int BEATS = 16,
  parameter int W     = $clog2(BEATS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Line miss/evict bridge: burst writeback of a dirty victim,
// then beat-wise refill reassembled into a full line.
module cache_mem_bridge
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = ADDR_BITS,
  parameter int LINE_SIZE_BYTES = LINE_BYTES,
  parameter int OFFSET_BITS     = OFFSET_W,
  parameter int MEM_DATA_WIDTH  = MEM_BEAT_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss_req,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  input  logic                         i_evict,
  input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_data,
  output logic                         o_ready,
  output logic [LINE_SIZE_BYTES*8-1:0] o_memory_line,
  output logic                         o_memory_response,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [MEM_DATA_WIDTH-1:0]    i_mem_rdata
);

  localparam int LW     = LINE_SIZE_BYTES * 8;
  localparam int NBEATS = LW / MEM_DATA_WIDTH;
  localparam int BW     = $clog2(NBEATS);
  localparam int BSHIFT = $clog2(MEM_DATA_WIDTH / 8);

  bridge_state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] miss_base;
  logic [ADDRESS_WIDTH-1:0] evict_base;
  logic [LW-1:0]            evict_buf;
  logic [LW-1:0]            line_buf;
  logic [LW-1:0]            out_line;
  logic [BW-1:0]            beat;
  logic                     last_beat;
  logic                     accept;
  logic                     busy;
  logic [ADDRESS_WIDTH-1:0] beat_off;

  assign accept   = (state == BR_IDLE) && i_miss_req;
  assign busy     = (state == BR_WB) || (state == BR_RD);
  assign beat_off = ADDRESS_WIDTH'(beat) << BSHIFT;

  beat_counter #(
    .BEATS (NBEATS),
    .W     (BW)
  ) u_beat (
    .clk   (clk),
    .rst   (rst),
    .en    (busy && i_mem_ack),
    .clr   (accept),
    .count (beat),
    .last  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BR_IDLE: if (i_miss_req) state_nxt = i_evict ? BR_WB : BR_RD;
      BR_WB:   if (i_mem_ack && last_beat) state_nxt = BR_RD;
      BR_RD:   if (i_mem_ack && last_beat) state_nxt = BR_RESP;
      BR_RESP: state_nxt = BR_IDLE;
      default: state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_base  <= '0;
      evict_base <= '0;
      evict_buf  <= '0;
      line_buf   <= '0;
      out_line   <= '0;
    end else begin
      if (accept) begin
        miss_base <= {i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS],
                      {OFFSET_BITS{1'b0}}};
        if (i_evict) begin
          evict_base <= {i_evict_addr[ADDRESS_WIDTH-1:OFFSET_BITS],
                         {OFFSET_BITS{1'b0}}};
          evict_buf  <= i_evict_data;
        end
      end
      if (state == BR_RD && i_mem_ack) begin
        line_buf[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= i_mem_rdata;
      end
      // out_line keeps the last refill visible after RESP
      if (state == BR_RESP) begin
        out_line <= line_buf;
      end
    end
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (1'b1)
      (state == BR_WB): begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = evict_base + beat_off;
        o_mem_wdata = evict_buf[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
      (state == BR_RD): begin
        o_mem_req  = 1'b1;
        o_mem_addr = miss_base + beat_off;
      end
      default: ;
    endcase
  end

  assign o_ready           = (state == BR_IDLE);
  assign o_memory_response = (state == BR_RESP);
  assign o_memory_line     = (state == BR_RESP) ? line_buf : out_line;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Randomized bench for cache_mem_bridge with a transaction-level
// model: expected beat sequence, refill line and handshake timing.
module tb_cache_mem_bridge;

  logic         clk;
  logic         rst;
  logic         i_miss_req;
  logic [31:0]  i_miss_addr;
  logic         i_evict;
  logic [31:0]  i_evict_addr;
  logic [511:0] i_evict_data;
  logic         o_ready;
  logic [511:0] o_memory_line;
  logic         o_memory_response;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [31:0]  o_mem_addr;
  logic [31:0]  o_mem_wdata;
  logic         i_mem_ack;
  logic [31:0]  i_mem_rdata;

  cache_mem_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss_req        (i_miss_req),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_ready           (o_ready),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rdata       (i_mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  mem [logic [31:0]];
  beat_t        q [$];
  logic [31:0]  log_addr [$];
  logic [31:0]  log_wdata [$];
  logic         busy_m = 0;
  logic         rsp_due = 0;
  logic [511:0] cur_line = '0;
  logic [511:0] hold_line = '0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           rsp_lat = 0;
  int           rsp_cnt = 0;
  int           ack_mode = 0;
  int           phase = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // memory port: ack pattern and same-cycle read data
  always @(posedge clk) begin
    #2;
    phase++;
    case (ack_mode)
      0:       i_mem_ack = 1'b1;
      1:       i_mem_ack = (phase % 3 == 0);
      default: i_mem_ack = 1'($urandom_range(0, 1));
    endcase
    i_mem_rdata = memrd(o_mem_addr);
  end

  // reference model and per-cycle compare
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      busy_m    = 0;
      rsp_due   = 0;
      hold_line = '0;
    end else begin
      chk("ready", o_ready, !busy_m);
      chk("rsp", o_memory_response, rsp_due);
      if (rsp_due) begin
        chk("rsp_req", o_mem_req, 0);
        chk("line", o_memory_line, cur_line);
        hold_line = cur_line;
        rsp_lat   = cyc - acc_cyc;
        rsp_cnt++;
        busy_m  = 0;
        rsp_due = 0;
      end else begin
        chk("line_hold", o_memory_line, hold_line);
        if (busy_m) begin
          beat_t b;
          b = q[0];
          chk("req", o_mem_req, 1);
          chk("we", o_mem_we, b.we);
          chk("addr", o_mem_addr, b.addr);
          if (b.we) chk("wdata", o_mem_wdata, b.wdata);
          if (i_mem_ack) begin
            if (b.we) mem[b.addr] = o_mem_wdata;
            log_addr.push_back(b.addr);
            log_wdata.push_back(b.wdata);
            void'(q.pop_front());
            if (q.size() == 0) rsp_due = 1;
          end
        end else begin
          chk("idle_req", o_mem_req, 0);
          if (i_miss_req) begin
            logic [31:0] mb, eb, a;
            mb = i_miss_addr & ~32'h3F;
            eb = i_evict_addr & ~32'h3F;
            log_addr.delete();
            log_wdata.delete();
            if (i_evict)
              for (int k = 0; k < 16; k++)
                q.push_back('{1'b1, eb + 32'(4 * k),
                              i_evict_data[32*k +: 32]});
            for (int k = 0; k < 16; k++) begin
              a = mb + 32'(4 * k);
              q.push_back('{1'b0, a, 32'h0});
              if (i_evict && a >= eb && a < eb + 64)
                cur_line[32*k +: 32] = i_evict_data[(a - eb) * 8 +: 32];
              else
                cur_line[32*k +: 32] = memrd(a);
            end
            busy_m  = 1;
            acc_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] ma, input logic ev,
                        input logic [31:0] ea, input logic [511:0] ed);
    int n;
    @(posedge clk);
    #2;
    i_miss_req   = 1;
    i_miss_addr  = ma;
    i_evict      = ev;
    i_evict_addr = ea;
    i_evict_data = ed;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 3000);
    if (n >= 3000) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    i_miss_req = 0;
    i_evict    = 0;
  endtask

  task automatic wait_rsp();
    int c0, n;
    c0 = rsp_cnt;
    n  = 0;
    while (rsp_cnt == c0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    logic [511:0] ed, idx_line;
    int n, c0;
    rst          = 1;
    i_miss_req   = 0;
    i_miss_addr  = 0;
    i_evict      = 0;
    i_evict_addr = 0;
    i_evict_data = 0;
    i_mem_ack    = 0;
    i_mem_rdata  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_req", o_mem_req, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_rsp", o_memory_response, 0);
    chk("rst_line", o_memory_line, 0);
    #1;
    rst = 0;

    // refill without evict, rdata = beat index
    for (int k = 0; k < 16; k++) begin
      mem[32'h1200 + 32'(4 * k)] = 32'(k);
      idx_line[32*k +: 32] = 32'(k);
    end
    ack_mode = 0;
    do_req(32'h0000_1234, 0, 0, 0);
    wait_rsp();
    chk("t1_lat", rsp_lat, 17);
    chk("t1_line", o_memory_line, idx_line);
    chk("t1_nbeats", log_addr.size(), 16);
    chk("t1_first", log_addr[0], 32'h1200);
    chk("t1_last", log_addr[15], 32'h123C);

    // evict then refill, ack every cycle
    for (int k = 0; k < 16; k++) ed[32*k +: 32] = 32'(8'hA0 + k);
    do_req(32'h0000_8000, 1, 32'h0000_4000, ed);
    wait_rsp();
    chk("t2_lat", rsp_lat, 33);
    chk("t2_wa0", log_addr[0], 32'h4000);
    chk("t2_wd0", log_wdata[0], 32'hA0);
    chk("t2_wd15", log_wdata[15], 32'hAF);
    chk("t2_ra0", log_addr[16], 32'h8000);
    chk("t2_mem", memrd(32'h403C), 32'hAF);

    // ack every third cycle
    ack_mode = 1;
    do_req(32'h0000_1234, 0, 0, 0);
    wait_rsp();
    chk("t3_line", o_memory_line, idx_line);
    chk("t3_slow", rsp_lat > 40, 1);

    // random traffic: held/stray requests, stray acks
    ack_mode = 2;
    c0 = rsp_cnt;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      i_miss_req   = 1'($urandom_range(0, 1));
      i_miss_addr  = 32'h10000 | 32'($urandom_range(0, 7) << 6)
                     | 32'($urandom_range(0, 63));
      i_evict      = 1'($urandom_range(0, 1));
      i_evict_addr = 32'h10000 | 32'($urandom_range(0, 7) << 6);
      for (int k = 0; k < 16; k++) i_evict_data[32*k +: 32] = $urandom;
    end
    i_miss_req = 0;
    i_evict    = 0;
    n = 0;
    while (busy_m && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("t4_timeout", 0, 1);
    chk("t4_some_rsp", rsp_cnt > c0, 1);

    // reset in the middle of a refill at beat 7
    ack_mode = 0;
    do_req(32'h0000_3000, 0, 0, 0);
    n = 0;
    while (log_addr.size() < 7 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("t5_timeout", 0, 1);
    @(posedge clk);
    #3;
    chk("t5_beat7", o_mem_addr, 32'h301C);
    rst = 1;
    #1;
    chk("t5_req", o_mem_req, 0);
    chk("t5_ready", o_ready, 1);
    chk("t5_rsp", o_memory_response, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    do_req(32'h0000_3040, 0, 0, 0);
    wait_rsp();
    chk("t5_restart", log_addr[0], 32'h3040);

    // same-line evict and miss
    ack_mode = 2;
    for (int k = 0; k < 16; k++) ed[32*k +: 32] = $urandom;
    do_req(32'h0000_2000, 1, 32'h0000_2000, ed);
    wait_rsp();
    chk("t6_line", o_memory_line, ed);
    chk("t6_order", log_addr[15], 32'h203C);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
